// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared widths, write-back source codes and MEM FSM states
package mem_access_stage_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int REG_SIZE   = 5;

  localparam logic [WORD_WIDTH-1:0] ZERO_WORD = '0;

  // Write-back source select codes; REG_SRC_MEM marks a load.
  localparam logic [1:0] REG_SRC_ALU = 2'd0;
  localparam logic [1:0] REG_SRC_MEM = 2'd1;
  localparam logic [1:0] REG_SRC_PC  = 2'd2;
  localparam logic [1:0] REG_SRC_IMM = 2'd3;

  typedef enum logic {
    MEM_IDLE   = 1'b0,
    MEM_ACCESS = 1'b1
  } mem_state_e;

  // Word address of a byte address (low two bits cleared).
  function automatic logic [WORD_WIDTH-1:0] word_align(input logic [WORD_WIDTH-1:0] a);
    return a & ~WORD_WIDTH'(3);
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory req/ack bus
// master: pipeline MEM stage (drives dmem_req/we/addr/wdata, receives dmem_ack/rdata)
// slave : data memory
interface mem_access_stage_if;
  import mem_access_stage_pkg::*;

  logic                  dmem_req;
  logic                  dmem_we;
  logic [WORD_WIDTH-1:0] dmem_addr;
  logic [WORD_WIDTH-1:0] dmem_wdata;
  logic                  dmem_ack;
  logic [WORD_WIDTH-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mem_access_stage_mem_wb.sv
// rtl/mem_access_stage_mem_wb.sv - MEM/WB pipeline register with load/bubble control
// load_i=1 captures the instruction fields (write enable masked by kill_we_i),
// load_i=0 inserts a bubble. Outputs are the registered *_o fields.
module mem_wb_reg
  import mem_access_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  kill_we_i,
  input  logic                  Regfile_we_i,
  input  logic [REG_SIZE-1:0]   writeRegAddr_i,
  input  logic [1:0]            regSrc_mux_i,
  input  logic [WORD_WIDTH-1:0] aluOut_i,
  input  logic [WORD_WIDTH-1:0] readData_i,
  output logic                  Regfile_we_o,
  output logic [REG_SIZE-1:0]   writeRegAddr_o,
  output logic [1:0]            regSrc_mux_o,
  output logic [WORD_WIDTH-1:0] aluOut_o,
  output logic [WORD_WIDTH-1:0] readData_o
);

  logic                  we_q;
  logic [REG_SIZE-1:0]   rd_q;
  logic [1:0]            src_q;
  logic [WORD_WIDTH-1:0] alu_q;
  logic [WORD_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rst || !load_i) begin
      we_q    <= 1'b0;
      rd_q    <= '0;
      src_q   <= '0;
      alu_q   <= ZERO_WORD;
      rdata_q <= ZERO_WORD;
    end else begin
      we_q    <= Regfile_we_i & ~kill_we_i;
      rd_q    <= writeRegAddr_i;
      src_q   <= regSrc_mux_i;
      alu_q   <= aluOut_i;
      rdata_q <= readData_i;
    end
  end

  assign Regfile_we_o   = we_q;
  assign writeRegAddr_o = rd_q;
  assign regSrc_mux_o   = src_q;
  assign aluOut_o       = alu_q;
  assign readData_o     = rdata_q;

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline MEM stage: data-memory req/ack handshake, stall, MEM/WB register
// Optional feature macro: MEM_MISALIGN_CHECK_EN (reject mem ops with aluOutM_i[1:0]!=0).
// Ports: clk/rst (sync, active-high); EX/MEM inputs *M_i; dmem bus (master modport);
//        stallM_o (combinational); MEM/WB outputs *W_o; bus_errW_o/misalign_errW_o one-cycle pulses.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Regfile_weM_i,
  input  logic                  DataMem_weM_i,
  input  logic [REG_SIZE-1:0]   writeRegAddrM_i,
  input  logic [1:0]            regSrc_muxM_i,
  input  logic [WORD_WIDTH-1:0] aluOutM_i,
  input  logic [WORD_WIDTH-1:0] writeDataM_i,
  mem_access_stage_if.master    dmem,
  output logic                  stallM_o,
  output logic                  Regfile_weW_o,
  output logic [REG_SIZE-1:0]   writeRegAddrW_o,
  output logic [1:0]            regSrc_muxW_o,
  output logic [WORD_WIDTH-1:0] aluOutW_o,
  output logic [WORD_WIDTH-1:0] readDataW_o,
  output logic                  bus_errW_o,
  output logic                  misalign_errW_o
);

  mem_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  req_q, we_q;
  logic [WORD_WIDTH-1:0] addr_q, wdata_q;
  logic                  bus_err_q, bus_err_d;
  logic                  misalign_q, misalign_d;

  logic                  mem_op, misaligned, timeout_hit;
  logic                  start_access, end_access;
  logic                  wb_load, wb_kill;
  logic [WORD_WIDTH-1:0] wb_rdata;

  assign mem_op = DataMem_weM_i | (regSrc_muxM_i == REG_SRC_MEM);

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned = |aluOutM_i[1:0];
`else
  assign misaligned = 1'b0;
`endif

  // Last allowed wait cycle; an ack in this same cycle still wins.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= MEM_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MEM_IDLE:   if (mem_op && !misaligned)          state_d = MEM_ACCESS;
      MEM_ACCESS: if (dmem.dmem_ack || timeout_hit)   state_d = MEM_IDLE;
      default:                                        state_d = MEM_IDLE;
    endcase
  end

  always_comb begin
    stallM_o     = 1'b0;
    wb_load      = 1'b0;
    wb_kill      = 1'b0;
    wb_rdata     = ZERO_WORD;
    start_access = 1'b0;
    end_access   = 1'b0;
    bus_err_d    = 1'b0;
    misalign_d   = 1'b0;
    cnt_d        = '0;
    case (state_q)
      MEM_IDLE: begin
        if (!mem_op) begin
          wb_load = 1'b1;
        end else if (misaligned) begin
          misalign_d = 1'b1;
        end else begin
          stallM_o     = 1'b1;
          start_access = 1'b1;
        end
      end
      MEM_ACCESS: begin
        if (dmem.dmem_ack) begin
          wb_load    = 1'b1;
          wb_kill    = we_q;
          wb_rdata   = we_q ? ZERO_WORD : dmem.dmem_rdata;
          end_access = 1'b1;
        end else if (timeout_hit) begin
          wb_load    = 1'b1;
          wb_kill    = 1'b1;
          bus_err_d  = 1'b1;
          end_access = 1'b1;
        end else begin
          stallM_o = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Request side: latched once on entry to ACCESS, held until retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= ZERO_WORD;
      wdata_q    <= ZERO_WORD;
      bus_err_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      bus_err_q  <= bus_err_d;
      misalign_q <= misalign_d;
      if (start_access) begin
        req_q   <= 1'b1;
        we_q    <= DataMem_weM_i;
        addr_q  <= word_align(aluOutM_i);
        wdata_q <= writeDataM_i;
      end else if (end_access) begin
        req_q <= 1'b0;
      end
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

  assign bus_errW_o      = bus_err_q;
  assign misalign_errW_o = misalign_q;

  mem_wb_reg u_mem_wb (
    .clk            (clk),
    .rst            (rst),
    .load_i         (wb_load),
    .kill_we_i      (wb_kill),
    .Regfile_we_i   (Regfile_weM_i),
    .writeRegAddr_i (writeRegAddrM_i),
    .regSrc_mux_i   (regSrc_muxM_i),
    .aluOut_i       (aluOutM_i),
    .readData_i     (wb_rdata),
    .Regfile_we_o   (Regfile_weW_o),
    .writeRegAddr_o (writeRegAddrW_o),
    .regSrc_mux_o   (regSrc_muxW_o),
    .aluOut_o       (aluOutW_o),
    .readData_o     (readDataW_o)
  );

endmodule
